// File: rtl/adder_pkg.sv
// Shared adder definitions: serial sequencer state encoding
// and counter sizing helper.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sadd_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/inf_serial_adder.sv
// Handshake bundle around serial_adder_ctrl for
// system-level benches.
interface inf_serial_adder #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport ctrl (
    input  clk, rst_n, flush,
    input  in_valid, op_a, op_b, cin, sub,
    output in_ready,
    output out_valid, sum, cout, ovf, busy,
    input  out_ready
  );

  modport src (
    input  clk, rst_n,
    output flush,
    output in_valid, op_a, op_b, cin, sub,
    input  in_ready,
    input  out_valid, sum, cout, ovf, busy,
    output out_ready
  );

endinterface

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder,
// LSB-first, registered carry, valid/ready on both sides.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sadd_state_e state;
  sadd_state_e state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             msb_step;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // sum_sh keeps only the upper WIDTH-1 bits; the MSB
  // step completes the word straight into the result.
  assign sum_nx   = {fa_sum, sum_sh};
  assign accept   = in_valid & in_ready & ~flush;
  assign msb_step = (state == S_RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) state_nx = S_RUN;
        S_RUN:  if (cnt == LAST) state_nx = S_DONE;
        S_DONE: if (out_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_RUN) || (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        a_sh  <= op_a;
        b_sh  <= sub ? ~op_b : op_b;
        carry <= sub | cin;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_nx[WIDTH-1:1];
        carry  <= fa_carry;
        cnt    <= cnt + 1'b1;
        if (msb_step) begin
          sum  <= sum_nx;
          cout <= fa_carry;
          ovf  <= carry ^ fa_carry;
        end
      end
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around a single instance of the team's 1-bit full_adder cell.
- Accepts a WIDTH-bit operand pair through a valid/ready handshake.
- Streams the operand bits LSB-first through the full_adder, one bit per clock, with a registered carry.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake.
- Serves as the area-minimal arithmetic path and as the sequencing harness for the full_adder cell in system-level benches.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; forces IDLE at the next edge.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands; high iff state is IDLE.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = compute A-B, 0 = compute A+B+cin.
- out_valid  output  1  result valid; high iff state is DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result word.
- cout  output  1  carry-out; for subtraction, 1 means no borrow.
- ovf  output  1  signed (two's-complement) overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE, so in_ready=1 during and after reset.
  - out_valid=0, busy=0; sum, cout and ovf registers = 0.
  - Bit counter, shift registers and carry register = 0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_valid & in_ready at an edge latches a_sh=op_a and b_sh = sub ? ~op_b : op_b.
  - Carry register is initialised to sub ? 1 : cin; bit counter cleared; next state RUN.
- RUN, each edge:
  - full_adder inputs are a=a_sh[0], b=b_sh[0], c=carry register.
  - sum_sh <= {fa.sum, sum_sh[WIDTH-1:1]}; carry <= fa.carry; a_sh and b_sh shift right by one; counter++.
  - When counter == WIDTH-1 (MSB step), the same edge:
    - loads result register sum = {fa.sum, sum_sh[WIDTH-1:1]};
    - sets cout = fa.carry and ovf = carry ^ fa.carry (carry into MSB XOR carry out of MSB);
    - moves to DONE.
- Latency: operands accepted at edge k give out_valid=1 in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - out_valid & out_ready at an edge moves to IDLE; in_ready rises in the following cycle.
  - No back-to-back overlap: in_ready=0 throughout RUN and DONE, and in_valid is ignored there.
- Result registers change only on the MSB step. They hold their value through IDLE, backpressure and flush.
- flush:
  - Highest priority among synchronous events, including simultaneous accept or output handshake.
  - Forces IDLE at the next edge; the operation is discarded and no out_valid pulse is produced.
  - Result registers are not modified.
  - flush in IDLE is a no-op; an accept attempted in the same cycle is not taken.
- Asynchronous reset mid-operation: immediate return to reset values with no clock required. The in-flight operation is lost.
- Operands are sampled only at the accept edge. Changes on op_a, op_b, cin or sub afterwards have no effect.

Decomposition:
- Shared package adder gains:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sadd_state_e;
  - a function for the counter width, $clog2(WIDTH).
- One sub-module: the existing full_adder, instantiated exactly once; no other arithmetic in the block.
- The interface inf_adder is extended with a companion interface inf_serial_adder (clk, rst_n and handshake signals) for the bench.

Test Plan (WIDTH=8):
1. A=8'h0F, B=8'h01, cin=0, sub=0 -> sum=8'h10, cout=0, ovf=0; out_valid rises exactly 8 cycles after the accept edge; busy high for the whole interval.
2. A=8'hFF, B=8'h01, cin=0 -> 8'h00, cout=1, ovf=0. Then A=8'h7F, B=8'h00, cin=1 -> 8'h80, cout=0, ovf=1.
3. sub=1, A=8'h05, B=8'h07 -> 8'hFE, cout=0, ovf=0. Then A=8'h80, B=8'h01, sub=1 -> 8'h7F, cout=1, ovf=1; cin=1 applied during both has no effect.
4. Backpressure: out_ready low for 5 cycles in DONE -> out_valid and sum stay stable, in_ready=0, and in_valid held high is not accepted. The next operand is accepted in the first cycle after the output handshake.
5. flush asserted during RUN after bit 3 -> IDLE at the next edge, no out_valid, result registers keep the previous values. A following A=8'h01, B=8'h01 -> 8'h02 proves the carry was reinitialised.
6. rst_n pulled low mid-RUN between clock edges -> out_valid=0, busy=0, sum=0, cout=0, ovf=0 immediately, and in_ready=1. After release the next operation completes correctly.
